// File: rtl/mps_seq_pkg.sv
// Shared constants for the operation-on sequence: step codes seen by the
// system FSM, fault causes, feedback bit positions and small helpers.
package mps_seq_pkg;

    // Step codes; the encoding is the externally visible o_op_on_fsm value.
    typedef enum logic [3:0] {
        ST_IDLE          = 4'd0,
        ST_DIS_OPEN      = 4'd1,
        ST_DIS_SETTLE    = 4'd2,
        ST_DIS_CHECK     = 4'd3,
        ST_SC_ON         = 4'd5,
        ST_SC_SETTLE     = 4'd6,
        ST_CHARGE        = 4'd7,
        ST_MAIN_ON       = 4'd9,
        ST_MAIN_SETTLE   = 4'd10,
        ST_SC_OFF        = 4'd11,
        ST_SC_OFF_SETTLE = 4'd12,
        ST_DONE          = 4'd14,
        ST_FAIL          = 4'd15
    } op_on_step_e;

    // Cause of the last failed run; FLT_NONE after a successful one.
    typedef enum logic [2:0] {
        FLT_NONE        = 3'd0,
        FLT_DIS_OPEN    = 3'd1,
        FLT_SC_ON       = 3'd2,
        FLT_CHG_TIMEOUT = 3'd3,
        FLT_MAIN        = 3'd4,
        FLT_SC_OFF      = 3'd5,
        FLT_ABORT       = 3'd6
    } op_on_fault_e;

    // Contactor auxiliary feedback bit positions.
    localparam int unsigned FB_W    = 3;
    localparam int unsigned FB_MAIN = 0;
    localparam int unsigned FB_SC   = 1;
    localparam int unsigned FB_DIS  = 2;

    // Busy means a run is in progress: not idle and not a terminal code.
    function automatic logic step_busy(input op_on_step_e s);
        return !(s inside {ST_IDLE, ST_DONE, ST_FAIL});
    endfunction

    // Largest of three timing parameters, used to size the shared counter.
    function automatic int unsigned max3(input int unsigned a,
                                         input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/mps_sync2.sv
// Two-flop synchronizer for asynchronous level inputs, asynchronous
// active-low clear.
module mps_sync2 #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    // First stage may go metastable; second stage gives it a cycle to resolve.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/mps_op_on_seq.sv
// Operation-on step sequencer: opens the discharge contactor, pre-charges
// the DC link through the slow-charge contactor, closes main, drops
// slow-charge, then reports DONE or FAIL for a short hold before idling.
module mps_op_on_seq
    import mps_seq_pkg::*;
#(
    parameter int unsigned T_MC_SETTLE   = 100000,
    parameter int unsigned T_CHG_TIMEOUT = 500000000,
    parameter int unsigned T_HOLD        = 2
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    input  logic        i_abort,
    input  logic [2:0]  i_mc_fb,
    input  logic [15:0] i_dc_v,
    input  logic [15:0] i_dc_th,
    output logic [3:0]  o_op_on_fsm,
    output logic        o_busy,
    output logic [2:0]  o_fault
);

    // One counter serves settle, charge-timeout and terminal-hold dwell.
    localparam int unsigned CNT_MAX = max3(T_MC_SETTLE, T_CHG_TIMEOUT, T_HOLD);
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(T_MC_SETTLE - 1);
    localparam logic [CNT_W-1:0] CHG_LAST    = CNT_W'(T_CHG_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(T_HOLD - 1);

    op_on_step_e      state;
    op_on_step_e      state_nxt;
    op_on_fault_e     fault;
    op_on_fault_e     fault_nxt;
    logic             busy;
    logic [CNT_W-1:0] cnt;

    logic [FB_W-1:0]  fb_s;
    logic             dc_ge;

    logic             settle_done;
    logic             chg_expired;
    logic             hold_done;

    mps_sync2 #(
        .WIDTH (FB_W)
    ) u_fb_sync (
        .clk   (i_clk),
        .rst_n (i_rst),
        .d     (i_mc_fb),
        .q     (fb_s)
    );

    // Registered charge-complete compare keeps the 16-bit comparator out of
    // the state-decode path.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            dc_ge <= 1'b0;
        end else begin
            dc_ge <= (i_dc_v >= i_dc_th);
        end
    end

    assign settle_done = (cnt == SETTLE_LAST);
    assign chg_expired = (cnt == CHG_LAST);
    assign hold_done   = (cnt == HOLD_LAST);

    // Next-step decode; abort overrides every step except idle and fail.
    always_comb begin
        state_nxt = state;
        fault_nxt = fault;
        if (state == ST_IDLE) begin
            if (i_start && !i_abort) begin
                state_nxt = ST_DIS_OPEN;
                fault_nxt = FLT_NONE;
            end
        end else if (i_abort && (state != ST_FAIL)) begin
            state_nxt = ST_FAIL;
            fault_nxt = FLT_ABORT;
        end else begin
            case (state)
                ST_DIS_OPEN: state_nxt = ST_DIS_SETTLE;
                ST_DIS_SETTLE: begin
                    if (settle_done) state_nxt = ST_DIS_CHECK;
                end
                ST_DIS_CHECK: begin
                    if (fb_s[FB_DIS]) begin
                        state_nxt = ST_SC_ON;
                    end else begin
                        state_nxt = ST_FAIL;
                        fault_nxt = FLT_DIS_OPEN;
                    end
                end
                ST_SC_ON: state_nxt = ST_SC_SETTLE;
                ST_SC_SETTLE: begin
                    if (settle_done) begin
                        if (fb_s[FB_SC]) begin
                            state_nxt = ST_CHARGE;
                        end else begin
                            state_nxt = ST_FAIL;
                            fault_nxt = FLT_SC_ON;
                        end
                    end
                end
                ST_CHARGE: begin
                    // Charge-complete is tested first so it wins a tie with
                    // the timeout on the final cycle.
                    if (dc_ge) begin
                        state_nxt = ST_MAIN_ON;
                    end else if (chg_expired) begin
                        state_nxt = ST_FAIL;
                        fault_nxt = FLT_CHG_TIMEOUT;
                    end
                end
                ST_MAIN_ON: state_nxt = ST_MAIN_SETTLE;
                ST_MAIN_SETTLE: begin
                    if (settle_done) begin
                        if (fb_s[FB_MAIN]) begin
                            state_nxt = ST_SC_OFF;
                        end else begin
                            state_nxt = ST_FAIL;
                            fault_nxt = FLT_MAIN;
                        end
                    end
                end
                ST_SC_OFF: state_nxt = ST_SC_OFF_SETTLE;
                ST_SC_OFF_SETTLE: begin
                    if (settle_done) begin
                        if (!fb_s[FB_SC]) begin
                            state_nxt = ST_DONE;
                        end else begin
                            state_nxt = ST_FAIL;
                            fault_nxt = FLT_SC_OFF;
                        end
                    end
                end
                ST_DONE, ST_FAIL: begin
                    if (hold_done) state_nxt = ST_IDLE;
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    // Step register with registered busy/fault; dwell counter restarts on
    // every step change and stays cleared while idle.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state <= ST_IDLE;
            fault <= FLT_NONE;
            busy  <= 1'b0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            fault <= fault_nxt;
            busy  <= step_busy(state_nxt);
            if ((state_nxt != state) || (state == ST_IDLE)) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign o_op_on_fsm = state;
    assign o_busy      = busy;
    assign o_fault     = fault;

endmodule

// File: tb/tb_mps_op_on_seq.sv
// Self-checking bench for mps_op_on_seq with short timing parameters.
module tb_mps_op_on_seq;

    localparam int S  = 4;
    localparam int TO = 20;
    localparam int H  = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        abort;
    logic [2:0]  fb;
    logic [15:0] dc_v;
    logic [15:0] dc_th;
    logic [3:0]  code;
    logic        busy;
    logic [2:0]  fault;

    int n_cmp = 0;
    int n_bad = 0;

    // reference model state
    int         m_code;
    int         m_fault;
    int         m_k;          // 1-based cycle index within current step
    logic       m_busy;
    logic [2:0] h1, h2;       // feedback values seen 1 and 2 edges ago
    bit         ge_prev;      // compare result seen 1 edge ago
    bit         auto_fb;
    logic [2:0] stuck;        // feedback bits forced to 0

    always #5 clk = ~clk;

    mps_op_on_seq #(
        .T_MC_SETTLE   (S),
        .T_CHG_TIMEOUT (TO),
        .T_HOLD        (H)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_start     (start),
        .i_abort     (abort),
        .i_mc_fb     (fb),
        .i_dc_v      (dc_v),
        .i_dc_th     (dc_th),
        .o_op_on_fsm (code),
        .o_busy      (busy),
        .o_fault     (fault)
    );

    // Plant model: discharge open from step 1, slow-charge closed 5..10,
    // main closed 9..14. Returns {dis, sc, main}.
    function automatic logic [2:0] contactors(input int c);
        logic [2:0] r;
        r[0] = (c >= 9) && (c <= 14);
        r[1] = (c >= 5) && (c <= 10);
        r[2] = (c >= 1) && (c <= 14);
        return r;
    endfunction

    function automatic void model_reset();
        m_code  = 0;
        m_fault = 0;
        m_k     = 1;
        m_busy  = 1'b0;
        h1      = '0;
        h2      = '0;
        ge_prev = 1'b0;
    endfunction

    // One clock edge of the sequencing rules.
    function automatic void model_step();
        logic [2:0] fs;
        bit ge;
        int nxt, nf;
        fs = h2;
        ge = ge_prev;
        h2 = h1;
        h1 = fb;
        ge_prev = (dc_v >= dc_th);
        nxt = m_code;
        nf  = m_fault;
        if (m_code == 0) begin
            if (start && !abort) begin nxt = 1; nf = 0; end
        end else if (abort && m_code != 15) begin
            nxt = 15; nf = 6;
        end else begin
            case (m_code)
                1:  nxt = 2;
                5:  nxt = 6;
                9:  nxt = 10;
                11: nxt = 12;
                2:  if (m_k == S) nxt = 3;
                3:  if (fs[2]) nxt = 5; else begin nxt = 15; nf = 1; end
                6:  if (m_k == S) begin
                        if (fs[1]) nxt = 7; else begin nxt = 15; nf = 2; end
                    end
                7:  if (ge) nxt = 9;
                    else if (m_k == TO) begin nxt = 15; nf = 3; end
                10: if (m_k == S) begin
                        if (fs[0]) nxt = 11; else begin nxt = 15; nf = 4; end
                    end
                12: if (m_k == S) begin
                        if (!fs[1]) nxt = 14; else begin nxt = 15; nf = 5; end
                    end
                14, 15: if (m_k == H) nxt = 0;
                default: nxt = 0;
            endcase
        end
        m_k     = (nxt != m_code) ? 1 : m_k + 1;
        m_code  = nxt;
        m_fault = nf;
        m_busy  = !(nxt == 0 || nxt == 14 || nxt == 15);
    endfunction

    // Advance one clock; DUT outputs are valid at the return (falling edge).
    task automatic tick();
        if (auto_fb) fb = contactors(m_code) & ~stuck;
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic test_reset();
        #3 rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_cmp++; if (code !== 4'd0) begin n_bad++; $display("FAIL reset_code got %0d exp 0", code); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %0b exp 0", busy); end
        n_cmp++; if (fault !== 3'd0) begin n_bad++; $display("FAIL reset_fault got %0d exp 0", fault); end
        rst = 1'b1;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if (code !== 4'(m_code) || busy !== m_busy || fault !== 3'(m_fault)) begin
                n_bad++;
                $display("FAIL reset_idle code=%0d/%0d busy=%0b/%0b fault=%0d/%0d (got/exp)",
                         code, m_code, busy, m_busy, fault, m_fault);
            end
        end
    endtask

    task automatic test_nominal();
        int exp_q[] = '{1,2,2,2,2,3,5,6,6,6,6,7,7,7,7,7,7,9,10,10,10,10,11,12,12,12,12,14,14,0};
        stuck = '0; dc_v = 16'd0; dc_th = 16'd1000;
        start = 1'b1;
        foreach (exp_q[i]) begin
            if (m_code == 7 && m_k == 5) dc_v = dc_th;
            tick();
            start = 1'b0;
            n_cmp++;
            if (code !== 4'(exp_q[i])) begin
                n_bad++;
                $display("FAIL nominal_seq step %0d got %0d exp %0d", i, code, exp_q[i]);
            end
            n_cmp++;
            if (code !== 4'(m_code) || busy !== m_busy || fault !== 3'(m_fault)) begin
                n_bad++;
                $display("FAIL nominal_model code=%0d/%0d busy=%0b/%0b fault=%0d/%0d (got/exp)",
                         code, m_code, busy, m_busy, fault, m_fault);
            end
        end
        n_cmp++; if (fault !== 3'd0) begin n_bad++; $display("FAIL nominal_fault got %0d exp 0", fault); end
        dc_v = 16'd0;
    endtask

    task automatic test_timeout();
        int n7 = 0, n15 = 0;
        stuck = '0; dc_v = 16'd0; dc_th = 16'd100;
        start = 1'b1;
        for (int i = 0; i < 80; i++) begin
            tick();
            start = 1'b0;
            n_cmp++;
            if (code !== 4'(m_code) || busy !== m_busy || fault !== 3'(m_fault)) begin
                n_bad++;
                $display("FAIL timeout_model code=%0d/%0d busy=%0b/%0b fault=%0d/%0d (got/exp)",
                         code, m_code, busy, m_busy, fault, m_fault);
            end
            if (code == 4'd7) n7++;
            if (code == 4'd15) n15++;
            if (m_code == 0) break;
        end
        n_cmp++; if (n7 != TO) begin n_bad++; $display("FAIL timeout_len7 got %0d exp %0d", n7, TO); end
        n_cmp++; if (n15 != H) begin n_bad++; $display("FAIL timeout_len15 got %0d exp %0d", n15, H); end
        n_cmp++; if (fault !== 3'd3) begin n_bad++; $display("FAIL timeout_fault got %0d exp 3", fault); end
        n_cmp++; if (code !== 4'd0) begin n_bad++; $display("FAIL timeout_idle got %0d exp 0", code); end
    endtask

    task automatic test_boundary();
        int n7 = 0, n9 = 0, n15 = 0;
        stuck = '0; dc_v = 16'd0; dc_th = 16'd500;
        start = 1'b1;
        for (int i = 0; i < 80; i++) begin
            if (m_code == 7 && m_k == TO - 1) dc_v = dc_th;
            tick();
            start = 1'b0;
            n_cmp++;
            if (code !== 4'(m_code) || busy !== m_busy || fault !== 3'(m_fault)) begin
                n_bad++;
                $display("FAIL boundary_model code=%0d/%0d busy=%0b/%0b fault=%0d/%0d (got/exp)",
                         code, m_code, busy, m_busy, fault, m_fault);
            end
            if (code == 4'd7) n7++;
            if (code == 4'd9) n9++;
            if (code == 4'd15) n15++;
            if (m_code == 0) break;
        end
        n_cmp++; if (n7 != TO) begin n_bad++; $display("FAIL boundary_len7 got %0d exp %0d", n7, TO); end
        n_cmp++; if (n9 != 1) begin n_bad++; $display("FAIL boundary_main_on got %0d exp 1", n9); end
        n_cmp++; if (n15 != 0) begin n_bad++; $display("FAIL boundary_no_fail got %0d exp 0", n15); end
        n_cmp++; if (fault !== 3'd0) begin n_bad++; $display("FAIL boundary_fault got %0d exp 0", fault); end
        dc_v = 16'd0;
    endtask

    task automatic test_fb_stuck();
        int n3 = 0, n15 = 0;
        stuck = 3'b100; dc_th = 16'd10; dc_v = 16'd10;
        start = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick();
            start = 1'b0;
            n_cmp++;
            if (code !== 4'(m_code) || busy !== m_busy || fault !== 3'(m_fault)) begin
                n_bad++;
                $display("FAIL stuck_model code=%0d/%0d busy=%0b/%0b fault=%0d/%0d (got/exp)",
                         code, m_code, busy, m_busy, fault, m_fault);
            end
            if (code == 4'd3) n3++;
            if (code == 4'd15) n15++;
            if (m_code == 0) break;
        end
        n_cmp++; if (n3 != 1) begin n_bad++; $display("FAIL stuck_check got %0d exp 1", n3); end
        n_cmp++; if (n15 != H) begin n_bad++; $display("FAIL stuck_fail_len got %0d exp %0d", n15, H); end
        n_cmp++; if (fault !== 3'd1) begin n_bad++; $display("FAIL stuck_fault got %0d exp 1", fault); end
        stuck = '0;
        start = 1'b1;
        tick();
        start = 1'b0;
        n_cmp++; if (code !== 4'd1) begin n_bad++; $display("FAIL restart_code got %0d exp 1", code); end
        n_cmp++; if (fault !== 3'd0) begin n_bad++; $display("FAIL restart_fault got %0d exp 0", fault); end
        for (int i = 0; i < 60; i++) begin
            tick();
            n_cmp++;
            if (code !== 4'(m_code) || busy !== m_busy || fault !== 3'(m_fault)) begin
                n_bad++;
                $display("FAIL restart_model code=%0d/%0d busy=%0b/%0b fault=%0d/%0d (got/exp)",
                         code, m_code, busy, m_busy, fault, m_fault);
            end
            if (m_code == 0) break;
        end
        n_cmp++; if (code !== 4'd0) begin n_bad++; $display("FAIL restart_idle got %0d exp 0", code); end
    endtask

    task automatic test_abort();
        stuck = '0; dc_th = 16'd10; dc_v = 16'd10;
        start = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick();
            start = 1'b0;
            if (m_code == 10) break;
        end
        n_cmp++; if (code !== 4'd10) begin n_bad++; $display("FAIL abort_reach10 got %0d exp 10", code); end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        n_cmp++; if (code !== 4'd15) begin n_bad++; $display("FAIL abort_code got %0d exp 15", code); end
        n_cmp++; if (fault !== 3'd6) begin n_bad++; $display("FAIL abort_fault got %0d exp 6", fault); end
        for (int i = 0; i < 10; i++) begin
            tick();
            if (m_code == 0) break;
        end
        n_cmp++; if (code !== 4'd0) begin n_bad++; $display("FAIL abort_idle got %0d exp 0", code); end
        abort = 1'b1;
        start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            start = 1'b0;
            n_cmp++;
            if (code !== 4'd0 || busy !== 1'b0) begin
                n_bad++;
                $display("FAIL abort_blocks_start code=%0d busy=%0b exp 0/0", code, busy);
            end
        end
        abort = 1'b0;
    endtask

    task automatic test_reset_mid();
        int n_term = 0;
        stuck = '0; dc_v = 16'd0; dc_th = 16'd100;
        start = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick();
            start = 1'b0;
            if (m_code == 7 && m_k == 3) break;
        end
        n_cmp++; if (code !== 4'd7) begin n_bad++; $display("FAIL rstmid_reach7 got %0d exp 7", code); end
        #2 rst = 1'b0;
        #1;
        n_cmp++; if (code !== 4'd0) begin n_bad++; $display("FAIL rstmid_async_code got %0d exp 0", code); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rstmid_async_busy got %0b exp 0", busy); end
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (code == 4'd14 || code == 4'd15) n_term++;
            n_cmp++;
            if (code !== 4'(m_code) || busy !== m_busy || fault !== 3'(m_fault)) begin
                n_bad++;
                $display("FAIL rstmid_model code=%0d/%0d busy=%0b/%0b fault=%0d/%0d (got/exp)",
                         code, m_code, busy, m_busy, fault, m_fault);
            end
        end
        n_cmp++; if (n_term != 0) begin n_bad++; $display("FAIL rstmid_terminal got %0d exp 0", n_term); end
    endtask

    task automatic test_random();
        stuck = '0; dc_v = 16'd0; dc_th = 16'd200;
        for (int i = 0; i < 2000; i++) begin
            start = 1'b0;
            if (m_code == 0 && ($urandom % 4) == 0) begin
                start = 1'b1;
                stuck = (($urandom % 4) == 0) ? 3'(1 << ($urandom % 3)) : 3'b000;
                dc_th = 16'($urandom_range(50, 400));
                dc_v  = 16'd0;
            end else if (($urandom % 50) == 0) begin
                start = 1'b1;
            end
            abort = (($urandom % 70) == 0);
            if (m_code == 7 && dc_v < 16'd60000) dc_v = dc_v + 16'($urandom_range(0, 25));
            tick();
            n_cmp++;
            if (code !== 4'(m_code) || busy !== m_busy || fault !== 3'(m_fault)) begin
                n_bad++;
                $display("FAIL random_model cyc %0d code=%0d/%0d busy=%0b/%0b fault=%0d/%0d (got/exp)",
                         i, code, m_code, busy, m_busy, fault, m_fault);
            end
        end
        start = 1'b0;
        abort = 1'b0;
        stuck = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; fb = '0;
        dc_v = '0; dc_th = '0; stuck = '0; auto_fb = 1'b1;
        model_reset();
        test_reset();
        test_nominal();
        test_timeout();
        test_boundary();
        test_fb_stuck();
        test_abort();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
